// File: rtl/fifo_wr_arbiter_if.sv
// Producer and FIFO-write-port bundle shared by the write arbiter.
// The slave side is the arbiter; the master side drives producers and FIFO flags.
interface fifo_wr_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    fifo_full;
    logic                    fifo_af;
    logic                    fifo_wr_en;
    logic [DATA_W-1:0]       fifo_wr_data;

    modport master (
        output req_valid,
        output req_data,
        output fifo_full,
        output fifo_af,
        input  req_ready,
        input  fifo_wr_en,
        input  fifo_wr_data
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  fifo_full,
        input  fifo_af,
        output req_ready,
        output fifo_wr_en,
        output fifo_wr_data
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among N_REQ producers.
// Accepted beats land on the FIFO port one cycle after the handshake.
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     syn_rst_n,
    fifo_wr_arbiter_if.slave         bus,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic                     burst_done,
    output logic [CNT_W-1:0]         beat_total
);
    localparam int ID_W = $clog2(N_REQ);
    localparam int BC_W = $clog2(MAX_BURST + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BC_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]  total_q, total_d;
    logic              wr_en_q, wr_en_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              done_q, done_d;

    logic              throttle;
    logic              sel_valid;
    logic [DATA_W-1:0] sel_data;
    logic              pick_found;
    logic [ID_W-1:0]   pick_id;
    logic              accept;
    logic              last_beat;
    logic [N_REQ-1:0]  ready_v;

    // Almost-full already leaves one slot for the beat still in the output flop.
    assign throttle = bus.fifo_full | bus.fifo_af;

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == grant_q) begin
                sel_valid = bus.req_valid[i];
                sel_data  = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Search starts just after the last owner, so it gets lowest priority.
    always_comb begin
        logic [ID_W-1:0] idx;
        pick_found = 1'b0;
        pick_id    = '0;
        idx        = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
            if (!pick_found && bus.req_valid[idx]) begin
                pick_found = 1'b1;
                pick_id    = idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        total_d    = total_q;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        ready_v    = '0;
        accept     = 1'b0;
        last_beat  = 1'b0;

        unique case (1'b1)
            (state_q == S_IDLE): begin
                if (pick_found && !throttle) begin
                    grant_d    = pick_id;
                    beat_cnt_d = '0;
                    state_d    = S_BURST;
                end
            end
            (state_q == S_BURST): begin
                ready_v[grant_q] = !throttle;
                accept    = sel_valid && !throttle;
                last_beat = (beat_cnt_q + BC_W'(1)) == BC_W'(MAX_BURST);
                if (accept) begin
                    wr_en_d    = 1'b1;
                    wr_data_d  = sel_data;
                    beat_cnt_d = beat_cnt_q + BC_W'(1);
                    total_d    = total_q + CNT_W'(1);
                end
                if ((accept && last_beat) || !sel_valid || throttle) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = grant_q;
                    done_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!syn_rst_n) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= ID_W'(N_REQ - 1);
            beat_cnt_q <= '0;
            total_q    <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            total_q    <= total_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
        end
    end

    assign bus.req_ready    = ready_v;
    assign bus.fifo_wr_en   = wr_en_q;
    assign bus.fifo_wr_data = wr_data_q;
    assign grant_id         = grant_q;
    assign busy             = (state_q == S_BURST);
    assign burst_done       = done_q;
    assign beat_total       = total_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed producer scenarios on one
// instance, a long single-producer run on a second instance for counter wrap.
module tb_fifo_wr_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       syn_rst_n;
    logic [1:0] grant_id;
    logic       busy;
    logic       burst_done;
    logic [15:0] beat_total;

    fifo_wr_arbiter_if #(.N_REQ(4), .DATA_W(8)) vif ();

    fifo_wr_arbiter #(
        .N_REQ(4), .DATA_W(8), .MAX_BURST(4), .CNT_W(16)
    ) dut (
        .clk(clk),
        .syn_rst_n(syn_rst_n),
        .bus(vif),
        .grant_id(grant_id),
        .busy(busy),
        .burst_done(burst_done),
        .beat_total(beat_total)
    );

    logic       w_rst_n;
    logic [1:0] w_grant;
    logic       w_busy;
    logic       w_done;
    logic [15:0] w_total;

    fifo_wr_arbiter_if #(.N_REQ(4), .DATA_W(8)) wif ();

    fifo_wr_arbiter #(
        .N_REQ(4), .DATA_W(8), .MAX_BURST(15), .CNT_W(16)
    ) dut_wrap (
        .clk(clk),
        .syn_rst_n(w_rst_n),
        .bus(wif),
        .grant_id(w_grant),
        .busy(w_busy),
        .burst_done(w_done),
        .beat_total(w_total)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int exp_data[$];
    int exp_gid[$];
    int exp_tot[$];

    int         rem[4];
    logic [3:0] acc_s;
    bit         wrap_done = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, act, act, req, req);
        end
    endtask

    always @(negedge clk) acc_s = vif.req_valid & vif.req_ready;

    // Producers: rem<0 means endless, rem==0 idle; valid follows at posedge+1.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc_s[i] && rem[i] > 0) rem[i]--;
            vif.req_valid[i] = (rem[i] != 0);
        end
    end

    // Monitor: FIFO writes and burst ends are checked against queued expectations.
    always @(negedge clk) begin
        if (vif.fifo_wr_en) begin
            if (exp_data.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL wr_unexpected: got data 0x%0h expected no write",
                         vif.fifo_wr_data);
            end else begin
                check("wr_data", int'(vif.fifo_wr_data), exp_data.pop_front());
            end
        end
        if (burst_done) begin
            if (exp_gid.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL done_unexpected: got grant %0d expected no burst end",
                         grant_id);
            end else begin
                check("done_grant", int'(grant_id), exp_gid.pop_front());
                check("done_total", int'(beat_total), exp_tot.pop_front());
            end
        end
    end

    task automatic push_data(input int d, input int n);
        for (int i = 0; i < n; i++) exp_data.push_back(d);
    endtask

    task automatic push_done(input int g, input int t);
        exp_gid.push_back(g);
        exp_tot.push_back(t);
    endtask

    task automatic settle(input string name);
        int k = 0;
        while (k < 400 && !(exp_data.size() == 0 && exp_gid.size() == 0 &&
                            !busy && vif.req_valid == 4'b0000)) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (k >= 400) begin
            n_fail++;
            $display("FAIL %s: timeout, %0d writes and %0d bursts outstanding",
                     name, exp_data.size(), exp_gid.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_accept(input int r);
        int k = 0;
        while (k < 50 && !(vif.req_valid[r] && vif.req_ready[r])) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (k >= 50) begin
            n_fail++;
            $display("FAIL accept_wait: requester %0d got no accept, expected one", r);
        end
    endtask

    // Second instance: requester 0 streams forever, flags low.
    initial begin
        int wcount = 0;
        int k = 0;
        w_rst_n        = 1'b0;
        wif.req_valid  = 4'b0001;
        wif.req_data   = {8'h00, 8'h00, 8'h00, 8'h5A};
        wif.fifo_full  = 1'b0;
        wif.fifo_af    = 1'b0;
        repeat (2) @(posedge clk);
        #2 w_rst_n = 1'b1;
        while (wcount < 70000 && k < 90000) begin
            @(negedge clk);
            k++;
            if (wif.fifo_wr_en) wcount++;
        end
        check("wrap_beats", wcount, 70000);
        check("wrap_total", int'(w_total), 4464);
        check("wrap_data", int'(wif.fifo_wr_data), 8'h5A);
        wrap_done = 1'b1;
    end

    initial begin
        int k;
        for (int i = 0; i < 4; i++) rem[i] = 0;
        acc_s          = '0;
        syn_rst_n      = 1'b0;
        vif.req_valid  = '0;
        vif.req_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        vif.fifo_full  = 1'b0;
        vif.fifo_af    = 1'b0;

        // Single producer, two back-to-back bursts of 4.
        rem[0] = 8;
        push_data(8'hA0, 8);
        push_done(0, 4);
        push_done(0, 8);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", int'(vif.req_ready), 0);
        check("rst_wr_en", int'(vif.fifo_wr_en), 0);
        check("rst_wr_data", int'(vif.fifo_wr_data), 0);
        check("rst_grant", int'(grant_id), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(burst_done), 0);
        check("rst_total", int'(beat_total), 0);
        @(posedge clk);
        #2 syn_rst_n = 1'b1;
        @(negedge clk);
        check("first_busy", int'(busy), 0);
        @(negedge clk);
        check("first_busy", int'(busy), 1);
        check("first_grant", int'(grant_id), 0);
        check("first_ready", int'(vif.req_ready), 4'b0001);
        settle("single_producer");

        // All four contend from reset: order 0,1,2,3,0.
        @(posedge clk);
        #2 syn_rst_n = 1'b0;
        @(posedge clk);
        #2 syn_rst_n = 1'b1;
        rem[0] = 8; rem[1] = 4; rem[2] = 4; rem[3] = 4;
        push_data(8'hA0, 4); push_data(8'hA1, 4);
        push_data(8'hA2, 4); push_data(8'hA3, 4);
        push_data(8'hA0, 4);
        push_done(0, 4); push_done(1, 8); push_done(2, 12);
        push_done(3, 16); push_done(0, 20);
        settle("round_robin");

        // Owner 2 stops after 2 beats; 3 takes over.
        @(posedge clk);
        #2;
        rem[2] = 2; rem[3] = 4;
        push_data(8'hA2, 2); push_data(8'hA3, 4);
        push_done(2, 22); push_done(3, 26);
        settle("early_drop");

        // Almost-full after first beat releases the grant.
        @(posedge clk);
        #2;
        rem[0] = 4;
        push_data(8'hA0, 1);
        push_done(0, 27);
        @(negedge clk);
        wait_accept(0);
        @(posedge clk);
        #2 vif.fifo_af = 1'b1;
        @(negedge clk);
        check("af_ready", int'(vif.req_ready), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("af_hold_busy", int'(busy), 0);
        end
        check("af_single_write", exp_data.size(), 0);
        push_data(8'hA0, 3);
        push_done(0, 30);
        @(posedge clk);
        #2 vif.fifo_af = 1'b0;
        settle("almost_full");

        // Reset during beat 2 of requester 1's burst.
        @(posedge clk);
        #2;
        rem[1] = 4;
        push_data(8'hA1, 1);
        @(negedge clk);
        wait_accept(1);
        @(posedge clk);
        #2;
        syn_rst_n = 1'b0;
        rem[0] = 2;
        @(posedge clk);
        #2 syn_rst_n = 1'b1;
        push_data(8'hA0, 2); push_data(8'hA1, 2);
        push_done(0, 2); push_done(1, 4);
        @(negedge clk);
        check("mid_rst_wr_en", int'(vif.fifo_wr_en), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_grant", int'(grant_id), 0);
        check("mid_rst_total", int'(beat_total), 0);
        check("mid_rst_done", int'(burst_done), 0);
        check("mid_rst_ready", int'(vif.req_ready), 0);
        @(negedge clk);
        check("post_rst_grant", int'(grant_id), 0);
        check("post_rst_busy", int'(busy), 1);
        settle("mid_reset");

        check("left_writes", exp_data.size(), 0);
        check("left_bursts", exp_gid.size(), 0);

        k = 0;
        while (!wrap_done && k < 90000) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (!wrap_done) begin
            n_fail++;
            $display("FAIL wrap_timeout: wrap run unfinished, expected finished");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
